// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one registered MIPS ALU among
// NREQ requesters. It picks one request per cycle, drives the ALU inputs,
// and tracks each issued operation so the ALU result comes back tagged with
// the ID of the requester that owns it.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = $clog2(NREQ),
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [4*NREQ-1:0]    req_op_i,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    output logic [3:0]           alu_control_o,
    output logic [31:0]          alu_in_0_o,
    output logic [31:0]          alu_in_1_o,
    input  logic [31:0]          alu_out_i,
    input  logic                 zero_flag_i,
    output logic                 rsp_valid_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_zero_o
);

    // Opcode the ALU treats as "no operation": it produces a result of 0.
    localparam logic [3:0] ALU_IDLE_OP = 4'b1111;

    // Requester index base+off, wrapping from NREQ-1 back to 0.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int              off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    logic                          found_s;
    logic [ID_W-1:0]               winner_s;
    logic [ID_W-1:0]               cand_s;
    logic                          issue_s;
    logic [ID_W-1:0]               ptr_q;
    logic [ID_W-1:0]               ptr_d;
    logic [ALU_LAT-1:0]            vld_q;
    logic [ALU_LAT-1:0]            vld_d;
    logic [ALU_LAT-1:0][ID_W-1:0]  id_q;
    logic [ALU_LAT-1:0][ID_W-1:0]  id_d;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = wrap_idx(ptr_q, k);
            if (!found_s && req_valid_i[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Nothing may issue while reset is held, so the grant is masked by rst_n.
    assign issue_s = found_s & rst_n;

    // Grant and ALU drive: winner's fields on issue, ALU idle values otherwise.
    always_comb begin
        req_ready_o   = '0;
        alu_control_o = ALU_IDLE_OP;
        alu_in_0_o    = 32'd0;
        alu_in_1_o    = 32'd0;
        if (issue_s) begin
            req_ready_o[winner_s] = 1'b1;
            alu_control_o         = req_op_i[int'(winner_s)*4 +: 4];
            alu_in_0_o            = req_a_i[int'(winner_s)*32 +: 32];
            alu_in_1_o            = req_b_i[int'(winner_s)*32 +: 32];
        end else begin
            req_ready_o = '0;
        end
    end

    // Next pointer: one past the winner on issue, otherwise unchanged.
    always_comb begin
        ptr_d = ptr_q;
        if (issue_s) begin
            ptr_d = wrap_idx(winner_s, 1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Tracking pipeline mirrors the ALU latency; id is zeroed on bubbles so
    // rsp_id reads 0 whenever no response is due.
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = issue_s;
        if (issue_s) begin
            id_d[0] = winner_s;
        end else begin
            id_d[0] = '0;
        end
        for (int s = 1; s < ALU_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    // State registers with synchronous active-low reset; reset drops all
    // in-flight operations and restarts the search at requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign rsp_valid_o = vld_q[ALU_LAT-1];
    assign rsp_id_o    = id_q[ALU_LAT-1];
    // The ALU shares rst_n, so these read 0 after reset and on idle cycles.
    assign rsp_data_o  = alu_out_i;
    assign rsp_zero_o  = zero_flag_i;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a registered MIPS ALU stand-in, a behavioural
// round-robin model with a response queue checked every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int LAT  = 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op = '0;
    logic [32*NREQ-1:0]   req_a = '0;
    logic [32*NREQ-1:0]   req_b = '0;
    logic [3:0]           alu_control;
    logic [31:0]          alu_in_0;
    logic [31:0]          alu_in_1;
    logic [31:0]          alu_out;
    logic                 zero_flag;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_zero;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic [NREQ-1:0] hold = '0;

    logic [NREQ-1:0] s_ready;
    logic [3:0]      s_ctrl;
    logic            s_rv;
    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rd;
    logic            s_rz;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .ALU_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .alu_control_o (alu_control),
        .alu_in_0_o    (alu_in_0),
        .alu_in_1_o    (alu_in_1),
        .alu_out_i     (alu_out),
        .zero_flag_i   (zero_flag),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .rsp_zero_o    (rsp_zero)
    );

    // MIPS ALU reference: {zero, result}; zero only for SUB with result 0.
    function automatic logic [32:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_NOR:  r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {((op == OP_SUB) && (r == 32'd0)), r};
    endfunction

    // Registered ALU stand-in sharing rst_n with the arbiter.
    always @(posedge clk) begin
        if (!rst_n) begin
            alu_out   <= 32'd0;
            zero_flag <= 1'b0;
        end else begin
            {zero_flag, alu_out} <= alu_ref(alu_control, alu_in_0, alu_in_1);
        end
    end

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
        logic [31:0]     d;
        logic            z;
    } rsp_t;

    rsp_t exp_q[$];
    int   m_ptr = 0;

    // First valid requester at or after m_ptr (cyclically); -1 if none.
    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Model state advances on each clock edge from the inputs of that cycle.
    always @(posedge clk) begin
        int   w;
        rsp_t e;
        if (!rst_n) begin
            m_ptr = 0;
            exp_q.delete();
            for (int s = 0; s < LAT; s++) exp_q.push_back('0);
        end else begin
            w = pick();
            e = '0;
            if (w >= 0) begin
                e.v = 1'b1;
                e.id = ID_W'(w);
                {e.z, e.d} = alu_ref(req_op[w*4 +: 4], req_a[w*32 +: 32], req_b[w*32 +: 32]);
                m_ptr = (w + 1) % NREQ;
            end
            exp_q.push_back(e);
            if (exp_q.size() > LAT) void'(exp_q.pop_front());
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        int              w;
        logic [NREQ-1:0] er;
        rsp_t            e;
        if (chk_en) begin
            w  = rst_n ? pick() : -1;
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            check("mdl_ready", 32'(req_ready), 32'(er));
            check("mdl_alu_ctrl", 32'(alu_control), (w >= 0) ? 32'(req_op[w*4 +: 4]) : 32'hF);
            check("mdl_alu_in0", alu_in_0, (w >= 0) ? req_a[w*32 +: 32] : 32'd0);
            check("mdl_alu_in1", alu_in_1, (w >= 0) ? req_b[w*32 +: 32] : 32'd0);
            e = exp_q[0];
            check("mdl_rsp_valid", 32'(rsp_valid), 32'(e.v));
            check("mdl_rsp_id", 32'(rsp_id), 32'(e.id));
            check("mdl_rsp_data", rsp_data, e.d);
            check("mdl_rsp_zero", 32'(rsp_zero), 32'(e.z));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(negedge clk);
        s_ready = req_ready;
        s_ctrl  = alu_control;
        s_rv    = rsp_valid;
        s_rid   = rsp_id;
        s_rd    = rsp_data;
        s_rz    = rsp_zero;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(s_ready & ~hold);
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_op[i*4 +: 4]   = op;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_rsp_valid", 32'(s_rv), 32'd0);
        check("rst_rsp_id", 32'(s_rid), 32'd0);
        check("rst_rsp_data", s_rd, 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_alu_ctrl", 32'(s_ctrl), 32'hF);

        // Single request: requester 2 ADD 5+7
        set_req(2, OP_ADD, 32'd5, 32'd7);
        cycle();
        check("single_ready", 32'(s_ready), 32'b0100);
        check("single_ctrl", 32'(s_ctrl), 32'(OP_ADD));
        cycle();
        check("single_rsp_valid", 32'(s_rv), 32'd1);
        check("single_rsp_id", 32'(s_rid), 32'd2);
        check("single_rsp_data", s_rd, 32'd12);
        check("single_rsp_zero", 32'(s_rz), 32'd0);
        // ptr is now 3: with 0 and 3 valid, 3 wins first
        set_req(0, OP_ADD, 32'd1, 32'd1);
        set_req(3, OP_ADD, 32'd2, 32'd2);
        cycle();
        check("ptr3_ready", 32'(s_ready), 32'b1000);
        cycle();
        check("ptr3_ready2", 32'(s_ready), 32'b0001);
        check("ptr3_rsp_id", 32'(s_rid), 32'd3);
        check("ptr3_rsp_data", s_rd, 32'd4);
        cycle();
        check("ptr3_rsp_id2", 32'(s_rid), 32'd0);
        check("ptr3_rsp_data2", s_rd, 32'd2);

        // All four valid continuously, SUB a-a, after reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        hold = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_SUB, 32'(100 + i), 32'(100 + i));
        for (int n = 0; n < 8; n++) begin
            cycle();
            check("rr_ready", 32'(s_ready), 32'd1 << (n % 4));
            if (n > 0) begin
                check("rr_rsp_valid", 32'(s_rv), 32'd1);
                check("rr_rsp_id", 32'(s_rid), 32'((n - 1) % 4));
                check("rr_rsp_data", s_rd, 32'd0);
                check("rr_rsp_zero", 32'(s_rz), 32'd1);
            end
        end
        hold = '0;
        req_valid = '0;
        set_req(1, OP_OR, 32'h0F0, 32'h00F);
        cycle();
        check("rr_last_rsp_id", 32'(s_rid), 32'd3);
        check("rr_last_rsp_zero", 32'(s_rz), 32'd1);
        check("ptr0_ready", 32'(s_ready), 32'b0010);

        // Requesters 1 and 3 with ptr=2: 3 first, then 1
        set_req(1, OP_AND, 32'hFF, 32'h3C);
        set_req(3, OP_OR, 32'h1, 32'h2);
        cycle();
        check("p2_ready_a", 32'(s_ready), 32'b1000);
        check("or_rsp_data", s_rd, 32'hFF);
        cycle();
        check("p2_ready_b", 32'(s_ready), 32'b0010);
        check("p2_rsp_id_a", 32'(s_rid), 32'd3);
        check("p2_rsp_data_a", s_rd, 32'd3);
        cycle();
        check("p2_rsp_valid_b", 32'(s_rv), 32'd1);
        check("p2_rsp_id_b", 32'(s_rid), 32'd1);
        check("p2_rsp_data_b", s_rd, 32'h3C);

        // Signed SLT and NOR
        set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        cycle();
        check("slt_ready", 32'(s_ready), 32'b0001);
        set_req(0, OP_SLT, 32'd1, 32'hFFFF_FFFF);
        cycle();
        check("slt_m1_1", s_rd, 32'd1);
        set_req(0, OP_NOR, 32'd0, 32'd0);
        cycle();
        check("slt_1_m1", s_rd, 32'd0);
        cycle();
        check("nor_data", s_rd, 32'hFFFF_FFFF);
        check("nor_zero", 32'(s_rz), 32'd0);

        // Reset mid-operation (ptr is 1 here)
        set_req(1, OP_ADD, 32'd3, 32'd4);
        rst_n = 1'b0;
        cycle();
        check("rstmid_ready", 32'(s_ready), 32'd0);
        req_valid = '0;
        set_req(0, OP_ADD, 32'd10, 32'd20);
        set_req(3, OP_ADD, 32'd30, 32'd40);
        rst_n = 1'b1;
        cycle();
        check("rstmid_rsp_valid", 32'(s_rv), 32'd0);
        check("rstmid_ready2", 32'(s_ready), 32'b0001);
        cycle();
        check("rstmid_rsp_id", 32'(s_rid), 32'd0);
        check("rstmid_rsp_data", s_rd, 32'd30);
        check("rstmid_ready3", 32'(s_ready), 32'b1000);
        cycle();
        check("rstmid_rsp_id2", 32'(s_rid), 32'd3);
        check("rstmid_rsp_data2", s_rd, 32'd70);

        // Undefined opcode 4'b1010 from requester 0
        cycle();
        check("undef_pre_ctrl", 32'(s_ctrl), 32'hF);
        check("undef_pre_valid", 32'(s_rv), 32'd0);
        set_req(0, 4'b1010, 32'd9, 32'd9);
        cycle();
        check("undef_ready", 32'(s_ready), 32'b0001);
        check("undef_ctrl", 32'(s_ctrl), 32'hA);
        cycle();
        check("undef_rsp_valid", 32'(s_rv), 32'd1);
        check("undef_rsp_id", 32'(s_rid), 32'd0);
        check("undef_rsp_data", s_rd, 32'd0);
        check("undef_rsp_zero", 32'(s_rz), 32'd0);
        check("undef_post_ctrl", 32'(s_ctrl), 32'hF);
        cycle();
        check("undef_post_valid", 32'(s_rv), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single registered MIPS ALU (AND/OR/ADD/SUB/SLT/NOR, 1-cycle latency, synchronous reset) among up to NREQ requesters. Example requesters are the execute stage, the branch comparator and the address generator. It selects one request per cycle and drives the ALU operation and operands. It tracks each in-flight operation through the ALU latency and returns the result, zero flag and requester ID. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- NREQ, 4: number of requesters, 2..8
- ID_W, $clog2(NREQ): width of the requester ID
- ALU_LAT, 1: ALU result latency in cycles, ≥1; must match the ALU instance
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  grant, one-hot or zero
- req_op  in  4*NREQ  ALU opcode per requester; requester i uses bits [4i+3:4i]
- req_a  in  32*NREQ  operand 0 per requester (signed)
- req_b  in  32*NREQ  operand 1 per requester (signed)
- alu_control  out  4  opcode to the ALU
- alu_in_0  out  32  operand 0 to the ALU
- alu_in_1  out  32  operand 1 to the ALU
- alu_out  in  32  ALU result
- zero_flag  in  1  ALU zero flag (set only for SUB)
- rsp_valid  out  1  result valid, one-cycle pulse
- rsp_id  out  ID_W  requester that owns the result
- rsp_data  out  32  result, equal to alu_out
- rsp_zero  out  1  zero flag, equal to zero_flag

## Operation
- **Handshake:** issue happens when req_valid[i] & req_ready[i].
  - Once valid is raised, a requester holds req_valid, req_op, req_a and req_b stable until it is granted.
  - req_valid must not depend on req_ready.
  - req_ready depends combinationally on req_valid.
- **Arbitration:** round-robin with pointer `ptr` (ID_W bits).
  - The search starts at `ptr` and wraps from NREQ-1 to 0. The first valid requester wins.
  - On issue, `ptr` becomes winner+1, wrapping to 0 after NREQ-1.
  - If nothing is issued, `ptr` holds.
- **ALU drive:**
  - On issue cycles, alu_control, alu_in_0 and alu_in_1 are combinational copies of the winner's fields.
  - On idle cycles they are 4'b1111, 0 and 0 (the ALU default, result 0).
- **Tracking:** a shift register of depth ALU_LAT holds (vld, id).
  - Stage 0 loads (issue, winner) every cycle.
  - rsp_valid is the vld bit of the last stage, and rsp_id is its id.
  - When the last stage is not valid, rsp_id is 0.
- **Response:** rsp_data and rsp_zero pass through from the ALU unconditionally. They are meaningful only while rsp_valid=1.
  - There is no response backpressure; the requester must accept the result.
- **Opcodes:** passed to the ALU unchecked. An undefined opcode still issues and returns rsp_data=0, rsp_zero=0.
- **Throughput:** one issue per cycle; the arbiter never stalls.
- **Fairness:** a continuously valid requester is granted within NREQ cycles.

## Timing
- **Reset (rst_n=0 at a clk edge):**
  - `ptr` becomes 0 and all tracking vld bits clear.
  - While rst_n=0, req_ready is all 0 and the ALU inputs hold idle values, so nothing issues.
  - After reset: rsp_valid=0, rsp_id=0.
  - rsp_data and rsp_zero read 0 because the ALU is reset by the same rst_n.
- **Latency:** an issue in cycle t gives rsp_valid=1 in cycle t+ALU_LAT, with rsp_id equal to the winner.
- **Back-to-back:** issues in consecutive cycles give responses in consecutive cycles, in issue order.
- **Reset mid-operation:** in-flight operations are dropped with no rsp_valid. The first issue after reset starts the search from requester 0.
- **Simultaneous requests:** exactly one grant per cycle. Losing requesters keep req_valid high and are considered the next cycle.
- **Request withdrawal:** a requester whose req_valid drops before it is granted is a protocol violation. The arbiter's behaviour is still defined: that requester is simply skipped.

## Test plan
- **Single request, after reset, NREQ=4:**
  - Stimulus: requester 2 sends ADD 5+7.
  - Required: req_ready=4'b0100 in cycle t; rsp_valid=1, rsp_id=2, rsp_data=12, rsp_zero=0 in cycle t+1; ptr=3.
- **All four requesters valid continuously, after reset, ops SUB a-a:**
  - Required: grant order 0,1,2,3,0,1,… one per cycle.
  - rsp_id follows the same order delayed by one cycle, with every rsp_data=0 and rsp_zero=1.
- **Requesters 1 and 3 valid, ptr=2:**
  - Required: 3 is granted first, then 1.
  - Responses: rsp_id=3 then rsp_id=1 in consecutive cycles.
- **Signed SLT and NOR:**
  - SLT -1,1 returns rsp_data=1.
  - SLT 1,-1 returns rsp_data=0.
  - NOR 0,0 returns 32'hFFFFFFFF with rsp_zero=0.
- **Reset mid-operation:**
  - Stimulus: issue in cycle t, rst_n=0 in cycle t.
  - Required: rsp_valid=0 in cycle t+1. After release, a grant with requesters 0 and 3 valid goes to requester 0.
- **Opcode 4'b1010 from requester 0:**
  - Required: issue is accepted; rsp_valid=1, rsp_data=0, rsp_zero=0.
  - Idle cycles around it: alu_control=4'b1111 and rsp_valid=0.
